// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic phase arbiter slice.
//   - LT_GREEN / LT_YELLOW / LT_RED : 3-bit lamp codes used by the lamp drivers
//   - phase_t                       : controller phase, encoding visible on the
//                                     arbiter's 'phase' output
//   - max_int                       : constant helper used to size timers
// ---------------------------------------------------------------------------
package traffic_pkg;

    localparam logic [2:0] LT_GREEN  = 3'b001;
    localparam logic [2:0] LT_YELLOW = 3'b010;
    localparam logic [2:0] LT_RED    = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        ALLRED = 2'd3
    } phase_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/traffic_rr_pick.sv
// ---------------------------------------------------------------------------
// traffic_rr_pick
// Combinational round-robin picker: returns the first set bit of 'pending'
// strictly after 'last_served', wrapping around to approach 0.
// Ports:
//   pending     in  N_APPR   outstanding requests
//   last_served in  IW       most recently served approach
//   winner      out IW       selected approach (last_served when nothing set)
//   any_valid   out 1        at least one request is pending
// ---------------------------------------------------------------------------
module traffic_rr_pick
    import traffic_pkg::*;
#(
    parameter int  N_APPR = 4,
    localparam int IW     = $clog2(N_APPR)
) (
    input  logic [N_APPR-1:0] pending,
    input  logic [IW-1:0]     last_served,
    output logic [IW-1:0]     winner,
    output logic              any_valid
);

    logic [IW-1:0] cand;

    // Walk the offsets from farthest to nearest so the candidate closest
    // after last_served is the one left standing at the end of the loop.
    always_comb begin
        winner = last_served;
        cand   = '0;
        for (int off = N_APPR; off >= 1; off--) begin
            cand = IW'((int'(last_served) + off) % N_APPR);
            if (pending[cand]) begin
                winner = cand;
            end
        end
    end

    assign any_valid = |pending;

endmodule

// File: rtl/traffic_phase_arbiter.sv
// ---------------------------------------------------------------------------
// traffic_phase_arbiter
// Demand-driven intersection sequencer. Shares green between N_APPR approaches
// in round-robin order, enforcing minimum/maximum green, yellow and all-red
// clearance times counted in 'tick' strobes.
// Ports:
//   clk          in  1          system clock
//   reset        in  1          asynchronous active-high reset
//   tick         in  1          timebase strobe; timers advance only on tick
//   req          in  N_APPR     level request per approach
//   preempt      in  1          (PREEMPT_EN only) emergency preemption request
//   preempt_idx  in  IW         (PREEMPT_EN only) approach to preempt for
//   lights       out 3*N_APPR   lamp code of approach i at [3i+2:3i]
//   grant_idx    out IW         approach currently green / last granted
//   grant_valid  out 1          high only in GREEN
//   phase        out 2          0 IDLE, 1 GREEN, 2 YELLOW, 3 ALLRED
// Optional feature: define PREEMPT_EN to add the preemption ports/behaviour.
// ---------------------------------------------------------------------------
module traffic_phase_arbiter
    import traffic_pkg::*;
#(
    parameter int  N_APPR    = 4,
    parameter int  MIN_GREEN = 5,
    parameter int  MAX_GREEN = 15,
    parameter int  YELLOW_T  = 3,
    parameter int  ALLRED_T  = 2,
    localparam int IW        = $clog2(N_APPR)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [N_APPR-1:0]   req,
`ifdef PREEMPT_EN
    input  logic                preempt,
    input  logic [IW-1:0]       preempt_idx,
`endif
    output logic [3*N_APPR-1:0] lights,
    output logic [IW-1:0]       grant_idx,
    output logic                grant_valid,
    output logic [1:0]          phase
);

    // The timer must be able to reach every phase limit; it saturates at the
    // largest one so a green resting indefinitely cannot wrap.
    localparam int            T_MAX    = max_int(max_int(MAX_GREEN, YELLOW_T), ALLRED_T);
    localparam int            TW       = $clog2(T_MAX + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_APPR - 1);

    phase_t              state_q, state_n;
    logic [TW-1:0]       timer_q, timer_n, timer_inc;
    logic [N_APPR-1:0]   pending_q, pending_n, pend_live, other;
    logic [IW-1:0]       last_q, last_n, grant_q, grant_n;
    logic [IW-1:0]       rr_winner, grant_to;
    logic                rr_any, demand, do_grant, grant_is_rr;
    logic                hold_green, force_yellow;
    logic [3*N_APPR-1:0] lights_n;
    logic                grant_valid_n;

    function automatic logic [N_APPR-1:0] onehot(input logic [IW-1:0] idx);
        logic [N_APPR-1:0] m;
        m = '0;
        for (int i = 0; i < N_APPR; i++) begin
            if (idx == IW'(i)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Requests arriving this clk join the pending set immediately so that a
    // grant decision made in the same cycle already sees them.
    assign pend_live = pending_q | req;
    assign other     = pend_live & ~onehot(grant_q);

    traffic_rr_pick #(
        .N_APPR(N_APPR)
    ) u_pick (
        .pending    (pend_live),
        .last_served(last_q),
        .winner     (rr_winner),
        .any_valid  (rr_any)
    );

`ifdef PREEMPT_EN
    logic          pre_q, pre_n;
    logic [IW-1:0] pre_idx_q, pre_idx_n;
    logic          pre_live;
    logic [IW-1:0] pre_target;

    // A preemption seen while clearing is latched so the grant at the end of
    // all-red still goes to the emergency approach even if the request pulse
    // has gone. A live request wins over an older latched one.
    assign pre_live     = preempt | pre_q;
    assign pre_target   = preempt ? preempt_idx : pre_idx_q;
    assign demand       = rr_any | pre_live;
    assign grant_to     = pre_live ? pre_target : rr_winner;
    assign grant_is_rr  = !pre_live;
    assign hold_green   = preempt && (state_q == GREEN) && (preempt_idx == grant_q);
    assign force_yellow = preempt && (state_q == GREEN) && (preempt_idx != grant_q);

    // Preemption latch: set by any preempt that is not simply holding the
    // current green, cleared as soon as a grant is issued.
    always_comb begin
        pre_n     = pre_q;
        pre_idx_n = pre_idx_q;
        if (preempt && !hold_green) begin
            pre_n     = 1'b1;
            pre_idx_n = preempt_idx;
        end
        if (do_grant) begin
            pre_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q     <= 1'b0;
            pre_idx_q <= '0;
        end else begin
            pre_q     <= pre_n;
            pre_idx_q <= pre_idx_n;
        end
    end
`else
    assign demand       = rr_any;
    assign grant_to     = rr_winner;
    assign grant_is_rr  = 1'b1;
    assign hold_green   = 1'b0;
    assign force_yellow = 1'b0;
`endif

    // Saturating tick counter value for this clk, before any phase change.
    always_comb begin
        timer_inc = timer_q;
        if (tick && (timer_q < TW'(T_MAX))) begin
            timer_inc = timer_q + TW'(1);
        end
    end

    // Next-state logic. Phase limits are compared against the post-tick
    // timer so a phase ends on the very clk that carries its completing tick.
    always_comb begin
        state_n   = state_q;
        timer_n   = timer_inc;
        pending_n = pend_live;
        last_n    = last_q;
        grant_n   = grant_q;
        do_grant  = 1'b0;

        case (state_q)
            ALLRED: begin
                if (timer_inc >= TW'(ALLRED_T)) begin
                    if (demand) begin
                        do_grant = 1'b1;
                    end else begin
                        state_n = IDLE;
                        timer_n = '0;
                    end
                end
            end
            IDLE: begin
                if (demand) begin
                    do_grant = 1'b1;
                end
            end
            GREEN: begin
                // The green approach never accumulates demand against itself.
                pending_n = other;
                if (force_yellow ||
                    (!hold_green && (other != '0) &&
                     ((timer_inc >= TW'(MIN_GREEN)) || (timer_inc >= TW'(MAX_GREEN))))) begin
                    state_n = YELLOW;
                    timer_n = '0;
                end
            end
            YELLOW: begin
                if (timer_inc >= TW'(YELLOW_T)) begin
                    state_n = ALLRED;
                    timer_n = '0;
                end
            end
            default: begin
                state_n = ALLRED;
                timer_n = '0;
            end
        endcase

        if (do_grant) begin
            state_n   = GREEN;
            timer_n   = '0;
            grant_n   = grant_to;
            pending_n = pend_live & ~onehot(grant_to);
            if (grant_is_rr) begin
                last_n = grant_to;
            end
        end
    end

    // Lamp codes are derived from the next state so they can be registered
    // alongside it; only the granted approach is ever non-red.
    always_comb begin
        lights_n      = {N_APPR{LT_RED}};
        grant_valid_n = (state_n == GREEN);
        for (int i = 0; i < N_APPR; i++) begin
            if (grant_n == IW'(i)) begin
                if (state_n == GREEN) begin
                    lights_n[3*i +: 3] = LT_GREEN;
                end else if (state_n == YELLOW) begin
                    lights_n[3*i +: 3] = LT_YELLOW;
                end
            end
        end
    end

    // State and output registers. Reset lands in all-red so the first green
    // after power-up still gets a full clearance interval.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ALLRED;
            timer_q     <= '0;
            pending_q   <= '0;
            last_q      <= LAST_IDX;
            grant_q     <= LAST_IDX;
            lights      <= {N_APPR{LT_RED}};
            grant_valid <= 1'b0;
        end else begin
            state_q     <= state_n;
            timer_q     <= timer_n;
            pending_q   <= pending_n;
            last_q      <= last_n;
            grant_q     <= grant_n;
            lights      <= lights_n;
            grant_valid <= grant_valid_n;
        end
    end

    assign grant_idx = grant_q;
    assign phase     = state_q;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// ---------------------------------------------------------------------------
// tb_traffic_phase_arbiter
// Self-checking bench for traffic_phase_arbiter with default parameters
// (N_APPR=4, MIN 5, MAX 15, YELLOW 3, ALLRED 2). When PREEMPT_EN is defined
// the preemption ports are connected and a preemption sequence is added.
// ---------------------------------------------------------------------------
module tb_traffic_phase_arbiter;
    import traffic_pkg::*;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           tick;
    logic [N-1:0]   req;
    logic [3*N-1:0] lights;
    logic [1:0]     grant_idx;
    logic           grant_valid;
    logic [1:0]     phase;
`ifdef PREEMPT_EN
    logic           preempt;
    logic [1:0]     preempt_idx;
`endif

    typedef struct {
        logic [3:0]  req;
        logic        tick;
        logic [1:0]  ph;
        logic [1:0]  gi;
        logic        gv;
        logic [11:0] lt;
    } vec_t;

    typedef struct {
        logic [1:0]  ph;
        logic [1:0]  gi;
        logic        gv;
        logic [11:0] lt;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[33];
    int   tests_run    = 0;
    int   tests_failed = 0;

    traffic_phase_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .req        (req),
`ifdef PREEMPT_EN
        .preempt    (preempt),
        .preempt_idx(preempt_idx),
`endif
        .lights     (lights),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    task automatic pushExpected(input logic [1:0] ph, input logic [1:0] gi,
                                input logic gv, input logic [11:0] lt);
        exp_t e;
        e.ph = ph;
        e.gi = gi;
        e.gv = gv;
        e.lt = lt;
        sb_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic t,
                                 input logic [1:0] ph, input logic [1:0] gi,
                                 input logic gv, input logic [11:0] lt);
        req  = r;
        tick = t;
        pushExpected(ph, gi, gv, lt);
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL %s: got no expected entry, required one queued", name);
        end else begin
            e = sb_q.pop_front();
            if (phase !== e.ph || grant_idx !== e.gi || grant_valid !== e.gv || lights !== e.lt) begin
                tests_failed++;
                $display("[TB] FAIL %s: got ph=%0d gi=%0d gv=%0d lights=%h, required ph=%0d gi=%0d gv=%0d lights=%h",
                         name, phase, grant_idx, grant_valid, lights, e.ph, e.gi, e.gv, e.lt);
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input logic t, input logic [1:0] ph,
                        input logic [1:0] gi, input logic gv, input logic [11:0] lt,
                        input string name);
        applyStimulus(r, t, ph, gi, gv, lt);
        @(negedge clk);
        checkOutput(name);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        tick  = 1'b0;
`ifdef PREEMPT_EN
        preempt     = 1'b0;
        preempt_idx = '0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pushExpected(2'd3, 2'd3, 1'b0, 12'h924);
        checkOutput("reset_state");
    endtask

    initial begin
        int          g_idx[$];
        int          g_len[$];
        int          run_len;
        logic        prev_gv;
        int          non_red;
        int          exp_order[5];

        reset = 1'b1;
        req   = '0;
        tick  = 1'b0;
`ifdef PREEMPT_EN
        preempt     = 1'b0;
        preempt_idx = '0;
`endif

        // Cycle-by-cycle vectors: {req, tick, phase, grant_idx, grant_valid, lights}
        tbl[0]  = '{4'h0, 1'b1, 2'd3, 2'd3, 1'b0, 12'h924};
        tbl[1]  = '{4'h0, 1'b0, 2'd3, 2'd3, 1'b0, 12'h924};
        tbl[2]  = '{4'h0, 1'b1, 2'd0, 2'd3, 1'b0, 12'h924};
        tbl[3]  = '{4'h0, 1'b1, 2'd0, 2'd3, 1'b0, 12'h924};
        tbl[4]  = '{4'h4, 1'b0, 2'd1, 2'd2, 1'b1, 12'h864};
        tbl[5]  = '{4'h0, 1'b1, 2'd1, 2'd2, 1'b1, 12'h864};
        tbl[6]  = '{4'h0, 1'b1, 2'd1, 2'd2, 1'b1, 12'h864};
        tbl[7]  = '{4'h1, 1'b0, 2'd1, 2'd2, 1'b1, 12'h864};
        tbl[8]  = '{4'h0, 1'b1, 2'd1, 2'd2, 1'b1, 12'h864};
        tbl[9]  = '{4'h0, 1'b1, 2'd1, 2'd2, 1'b1, 12'h864};
        tbl[10] = '{4'h0, 1'b1, 2'd2, 2'd2, 1'b0, 12'h8A4};
        tbl[11] = '{4'h0, 1'b1, 2'd2, 2'd2, 1'b0, 12'h8A4};
        tbl[12] = '{4'h0, 1'b0, 2'd2, 2'd2, 1'b0, 12'h8A4};
        tbl[13] = '{4'h0, 1'b1, 2'd2, 2'd2, 1'b0, 12'h8A4};
        tbl[14] = '{4'h0, 1'b1, 2'd3, 2'd2, 1'b0, 12'h924};
        tbl[15] = '{4'h0, 1'b1, 2'd3, 2'd2, 1'b0, 12'h924};
        tbl[16] = '{4'h8, 1'b1, 2'd1, 2'd3, 1'b1, 12'h324};
        tbl[17] = '{4'h0, 1'b1, 2'd1, 2'd3, 1'b1, 12'h324};
        tbl[18] = '{4'h0, 1'b1, 2'd1, 2'd3, 1'b1, 12'h324};
        tbl[19] = '{4'h0, 1'b1, 2'd1, 2'd3, 1'b1, 12'h324};
        tbl[20] = '{4'h0, 1'b1, 2'd1, 2'd3, 1'b1, 12'h324};
        tbl[21] = '{4'h0, 1'b1, 2'd2, 2'd3, 1'b0, 12'h524};
        tbl[22] = '{4'h0, 1'b1, 2'd2, 2'd3, 1'b0, 12'h524};
        tbl[23] = '{4'h0, 1'b1, 2'd2, 2'd3, 1'b0, 12'h524};
        tbl[24] = '{4'h0, 1'b1, 2'd3, 2'd3, 1'b0, 12'h924};
        tbl[25] = '{4'h0, 1'b1, 2'd3, 2'd3, 1'b0, 12'h924};
        tbl[26] = '{4'h0, 1'b1, 2'd1, 2'd0, 1'b1, 12'h921};
        tbl[27] = '{4'h0, 1'b1, 2'd1, 2'd0, 1'b1, 12'h921};
        tbl[28] = '{4'h2, 1'b0, 2'd1, 2'd0, 1'b1, 12'h921};
        tbl[29] = '{4'h0, 1'b1, 2'd1, 2'd0, 1'b1, 12'h921};
        tbl[30] = '{4'h0, 1'b1, 2'd1, 2'd0, 1'b1, 12'h921};
        tbl[31] = '{4'h0, 1'b1, 2'd1, 2'd0, 1'b1, 12'h921};
        tbl[32] = '{4'h0, 1'b1, 2'd2, 2'd0, 1'b0, 12'h922};

        // Table sequence: idle entry, min green, yellow/all-red, round robin
        doReset();
        for (int i = 0; i < 33; i++) begin
            step(tbl[i].req, tbl[i].tick, tbl[i].ph, tbl[i].gi, tbl[i].gv, tbl[i].lt,
                 $sformatf("vec%0d", i));
        end

        // IDLE latency and rest-in-green with no competing demand
        doReset();
        step(4'h0, 1'b1, 2'd3, 2'd3, 1'b0, 12'h924, "A_allred1");
        step(4'h0, 1'b1, 2'd0, 2'd3, 1'b0, 12'h924, "A_idle");
        step(4'h4, 1'b0, 2'd1, 2'd2, 1'b1, 12'h864, "A_latency");
        for (int i = 0; i < 50; i++) begin
            step(4'h0, 1'b1, 2'd1, 2'd2, 1'b1, 12'h864, $sformatf("A_rest%0d", i));
        end

        // All approaches requesting: order 0,1,2,3,0, 5-tick greens, one lamp lit
        doReset();
        exp_order = '{0, 1, 2, 3, 0};
        run_len   = 0;
        prev_gv   = 1'b0;
        for (int c = 0; c < 48; c++) begin
            req  = 4'hF;
            tick = 1'b1;
            @(negedge clk);
            non_red = 0;
            for (int i = 0; i < N; i++) begin
                if (lights[3*i +: 3] != LT_RED) non_red++;
            end
            tests_run++;
            if (non_red > 1) begin
                tests_failed++;
                $display("[TB] FAIL B_one_lamp c%0d: got %0d non-red approaches, required at most 1", c, non_red);
            end
            if (grant_valid) begin
                if (!prev_gv) begin
                    g_idx.push_back(int'(grant_idx));
                    run_len = 0;
                end
                run_len++;
            end else if (prev_gv) begin
                g_len.push_back(run_len);
            end
            prev_gv = grant_valid;
        end
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (k >= g_len.size() || k >= g_idx.size()) begin
                tests_failed++;
                $display("[TB] FAIL B_grant%0d: got only %0d completed greens, required 5", k, g_len.size());
            end else if (g_idx[k] != exp_order[k] || g_len[k] != 5) begin
                tests_failed++;
                $display("[TB] FAIL B_grant%0d: got idx=%0d len=%0d, required idx=%0d len=5",
                         k, g_idx[k], g_len[k], exp_order[k]);
            end
        end

        // Asynchronous reset in the middle of yellow clears everything at once
        pushExpected(2'd2, 2'd0, 1'b0, 12'h922);
        checkOutput("C_pre_yellow");
        req  = '0;
        tick = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        pushExpected(2'd3, 2'd3, 1'b0, 12'h924);
        checkOutput("C_async_reset");
        @(negedge clk);
        reset = 1'b0;
        step(4'h0, 1'b1, 2'd3, 2'd3, 1'b0, 12'h924, "C_allred1");
        step(4'h0, 1'b1, 2'd0, 2'd3, 1'b0, 12'h924, "C_idle_no_pending");
        step(4'h0, 1'b0, 2'd0, 2'd3, 1'b0, 12'h924, "C_idle_hold");

`ifdef PREEMPT_EN
        // Preempt approach 1's green for approach 3; round robin then resumes at 2
        doReset();
        step(4'h2, 1'b1, 2'd3, 2'd3, 1'b0, 12'h924, "P_allred1");
        step(4'h0, 1'b1, 2'd1, 2'd1, 1'b1, 12'h90C, "P_green1");
        step(4'h0, 1'b1, 2'd1, 2'd1, 1'b1, 12'h90C, "P_green1_t1");
        preempt     = 1'b1;
        preempt_idx = 2'd3;
        step(4'h0, 1'b0, 2'd2, 2'd1, 1'b0, 12'h914, "P_yellow_now");
        preempt = 1'b0;
        step(4'h0, 1'b1, 2'd2, 2'd1, 1'b0, 12'h914, "P_yellow1");
        step(4'h0, 1'b1, 2'd2, 2'd1, 1'b0, 12'h914, "P_yellow2");
        step(4'h0, 1'b1, 2'd3, 2'd1, 1'b0, 12'h924, "P_allred");
        step(4'h5, 1'b1, 2'd3, 2'd1, 1'b0, 12'h924, "P_allred_t1");
        step(4'h0, 1'b1, 2'd1, 2'd3, 1'b1, 12'h324, "P_green3");
        for (int i = 0; i < 4; i++) begin
            step(4'h0, 1'b1, 2'd1, 2'd3, 1'b1, 12'h324, $sformatf("P_green3_%0d", i));
        end
        step(4'h0, 1'b1, 2'd2, 2'd3, 1'b0, 12'h524, "P_yellow3");
        step(4'h0, 1'b1, 2'd2, 2'd3, 1'b0, 12'h524, "P_yellow3_1");
        step(4'h0, 1'b1, 2'd2, 2'd3, 1'b0, 12'h524, "P_yellow3_2");
        step(4'h0, 1'b1, 2'd3, 2'd3, 1'b0, 12'h924, "P_allred3");
        step(4'h0, 1'b1, 2'd3, 2'd3, 1'b0, 12'h924, "P_allred3_1");
        step(4'h0, 1'b1, 2'd1, 2'd2, 1'b1, 12'h864, "P_rr_resume2");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
